chfilt_coef_ctrl: RTL and testbench

CHFILT_COEF_CTRL -- requirements
Module: chfilt_coef_ctrl

---
 rtl/chfilt_coef_ctrl.sv | 171 +++++++++++++++++
 tb/tb_chfilt_coef_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chfilt_coef_ctrl.sv
// Channel-filter coefficient controller: host shadow bank, commit/strobe-synchronised tap load.
// Optional readback port enabled by defining COEF_READBACK_EN.
module chfilt_coef_ctrl #(
   parameter int NUM_COEF = 17,
   parameter int NBT_COEF = 8,
   parameter int NB_ADDR  = 5
) (
   input  logic                clk,
   input  logic                i_reset,
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   input  logic [NB_ADDR-1:0]  i_wr_addr,
   input  logic [NBT_COEF-1:0] i_wr_data,
   input  logic                i_commit,
   input  logic                i_sym_strobe,
   output logic                o_coef_we,
   output logic [NB_ADDR-1:0]  o_coef_addr,
   output logic [NBT_COEF-1:0] o_coef_data,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
`ifdef COEF_READBACK_EN
   ,
   input  logic [NB_ADDR-1:0]  i_rd_addr,
   output logic [NBT_COEF-1:0] o_rd_data
`endif
);

   localparam logic [NB_ADDR-1:0] LAST_TAP = NB_ADDR'(NUM_COEF - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      LOAD,
      DONE
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [NBT_COEF-1:0]  shadow [NUM_COEF];
   logic [NB_ADDR-1:0]   tap_cnt;
   logic [NB_ADDR-1:0]   tap_cnt_next;
   logic                 wr_legal;
   logic                 wr_en;
   logic                 we_next;
   logic [NB_ADDR-1:0]   addr_next;
   logic [NBT_COEF-1:0]  data_next;
   logic                 done_next;
   logic                 busy_next;
   logic                 ready_next;
   logic                 err_next;

   assign wr_legal = (i_wr_addr <= LAST_TAP);

   // Writes are only accepted in IDLE, so the shadow bank is already frozen
   // from the strobe until the load completes; no separate snapshot is kept.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int unsigned i = 0; i < NUM_COEF; i++) begin
            shadow[i] <= '0;
         end
      end else if (wr_en) begin
         shadow[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= IDLE;
         tap_cnt     <= '0;
         o_coef_we   <= 1'b0;
         o_coef_addr <= '0;
         o_coef_data <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         o_wr_ready  <= 1'b1;
      end else begin
         state       <= state_next;
         tap_cnt     <= tap_cnt_next;
         o_coef_we   <= we_next;
         o_coef_addr <= addr_next;
         o_coef_data <= data_next;
         o_busy      <= busy_next;
         o_done      <= done_next;
         o_err       <= err_next;
         o_wr_ready  <= ready_next;
      end
   end

   always_comb begin
      state_next   = state;
      tap_cnt_next = tap_cnt;
      wr_en        = 1'b0;
      we_next      = 1'b0;
      addr_next    = '0;
      data_next    = '0;
      done_next    = 1'b0;
      err_next     = o_err;

      case (state)
         IDLE: begin
            if (i_wr_valid) begin
               if (wr_legal) begin
                  wr_en = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
            if (i_commit) begin
               state_next = ARMED;
            end
         end

         ARMED: begin
            if (i_commit) begin
               err_next = 1'b1;
            end
            if (i_sym_strobe) begin
               state_next   = LOAD;
               tap_cnt_next = '0;
               we_next      = 1'b1;
               data_next    = shadow[0];
            end
         end

         LOAD: begin
            if (i_commit) begin
               err_next = 1'b1;
            end
            // tap_cnt holds the tap currently on the outputs; it saturates at the last tap
            if (tap_cnt == LAST_TAP) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               tap_cnt_next = tap_cnt + 1'b1;
               we_next      = 1'b1;
               addr_next    = tap_cnt_next;
               data_next    = shadow[tap_cnt_next];
            end
         end

         DONE: begin
            if (i_commit) begin
               err_next = 1'b1;
            end
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next  = (state_next == ARMED) || (state_next == LOAD);
      ready_next = (state_next == IDLE);
   end

`ifdef COEF_READBACK_EN
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         o_rd_data <= '0;
      end else if (i_rd_addr <= LAST_TAP) begin
         o_rd_data <= shadow[i_rd_addr];
      end else begin
         o_rd_data <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_chfilt_coef_ctrl.sv
// Self-checking bench for chfilt_coef_ctrl: scenario tasks plus a scoreboard of expected taps.
module tb_chfilt_coef_ctrl;

   localparam int NUM_COEF = 17;
   localparam int NBT_COEF = 8;
   localparam int NB_ADDR  = 5;

   logic                clk;
   logic                i_reset;
   logic                i_wr_valid;
   logic                o_wr_ready;
   logic [NB_ADDR-1:0]  i_wr_addr;
   logic [NBT_COEF-1:0] i_wr_data;
   logic                i_commit;
   logic                i_sym_strobe;
   logic                o_coef_we;
   logic [NB_ADDR-1:0]  o_coef_addr;
   logic [NBT_COEF-1:0] o_coef_data;
   logic                o_busy;
   logic                o_done;
   logic                o_err;

   int checks = 0;
   int errors = 0;

   logic [NBT_COEF-1:0]         model [NUM_COEF];
   logic [NB_ADDR+NBT_COEF-1:0] sb [$];

   chfilt_coef_ctrl #(
      .NUM_COEF (NUM_COEF),
      .NBT_COEF (NBT_COEF),
      .NB_ADDR  (NB_ADDR)
   ) dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_wr_valid   (i_wr_valid),
      .o_wr_ready   (o_wr_ready),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data),
      .i_commit     (i_commit),
      .i_sym_strobe (i_sym_strobe),
      .o_coef_we    (o_coef_we),
      .o_coef_addr  (o_coef_addr),
      .o_coef_data  (o_coef_data),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tap monitor: every emitted tap must match the head of the scoreboard.
   always @(negedge clk) begin
      logic [NB_ADDR+NBT_COEF-1:0] exp_tap;
      checks++;
      if (o_coef_we) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL tap_unexpected addr=%0d data=%h, scoreboard empty", o_coef_addr, o_coef_data);
         end else begin
            exp_tap = sb.pop_front();
            if ({o_coef_addr, o_coef_data} !== exp_tap) begin
               errors++;
               $display("FAIL tap_value got addr=%0d data=%h expected addr=%0d data=%h",
                        o_coef_addr, o_coef_data, exp_tap[NBT_COEF +: NB_ADDR], exp_tap[NBT_COEF-1:0]);
            end
         end
      end else if (o_coef_addr !== '0 || o_coef_data !== '0) begin
         errors++;
         $display("FAIL idle_outputs_zero got addr=%0d data=%h expected 0/00", o_coef_addr, o_coef_data);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_cycle(input logic v, input logic [NB_ADDR-1:0] a,
                              input logic [NBT_COEF-1:0] d, input logic c, input logic s);
      @(negedge clk);
      i_wr_valid   = v;
      i_wr_addr    = a;
      i_wr_data    = d;
      i_commit     = c;
      i_sym_strobe = s;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic push_model();
      for (int i = 0; i < NUM_COEF; i++) sb.push_back({NB_ADDR'(i), model[i]});
   endtask

   task automatic apply_reset();
      @(negedge clk);
      i_reset = 1'b0;
      for (int i = 0; i < NUM_COEF; i++) model[i] = '0;
      sb.delete();
      idle_cycles(2);
      @(negedge clk);
      i_reset = 1'b1;
   endtask

   // Strobe in cycle N, then observe N+1..N+30. inj_k injects commit+write, rst_k asserts reset mid-cycle.
   task automatic run_load(input int inj_k, input int rst_k, output int first_we, output int we_cnt,
                           output int done_at, output int done_cnt, output logic we_after_rst);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      first_we = 0; we_cnt = 0; done_at = 0; done_cnt = 0; we_after_rst = 1'bx;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (o_coef_we) begin
            if (first_we == 0) first_we = k;
            we_cnt++;
         end
         if (o_done) begin
            done_at = k;
            done_cnt++;
         end
         i_sym_strobe = 1'b0;
         i_commit     = 1'b0;
         i_wr_valid   = 1'b0;
         if (k == inj_k) begin
            i_commit   = 1'b1;
            i_wr_valid = 1'b1;
            i_wr_addr  = 5'd3;
            i_wr_data  = 8'h11;
         end
         if (k == rst_k) begin
            #2 i_reset = 1'b0;
            #1 we_after_rst = o_coef_we;
         end
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b0; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      i_commit = 1'b0; i_sym_strobe = 1'b0;
      for (int i = 0; i < NUM_COEF; i++) model[i] = '0;
      idle_cycles(2);
      checks++;
      if ({o_wr_ready, o_busy, o_done, o_err, o_coef_we} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags got ready/busy/done/err/we=%b expected 10000",
                  {o_wr_ready, o_busy, o_done, o_err, o_coef_we});
      end
      @(negedge clk);
      i_reset = 1'b1;
      idle_cycles(1);
      checks++;
      if (o_wr_ready !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle got ready=%b busy=%b expected 1/0", o_wr_ready, o_busy);
      end
   endtask

   task automatic test_basic_load();
      int fw, wc, da, dc;
      logic war;
      for (int k = 0; k < NUM_COEF; k++) begin
         drive_cycle(1'b1, NB_ADDR'(k), NBT_COEF'(k + 1), 1'b0, 1'b0);
         model[k] = NBT_COEF'(k + 1);
      end
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      idle_cycles(2);
      push_model();
      run_load(0, 0, fw, wc, da, dc, war);
      checks++;
      if (fw !== 1 || wc !== NUM_COEF) begin
         errors++;
         $display("FAIL basic_we_window got first=%0d count=%0d expected 1/%0d", fw, wc, NUM_COEF);
      end
      checks++;
      if (da !== NUM_COEF + 1 || dc !== 1) begin
         errors++;
         $display("FAIL basic_done got at=%0d count=%0d expected %0d/1", da, dc, NUM_COEF + 1);
      end
      checks++;
      if (sb.size() !== 0 || o_err !== 1'b0 || o_wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_end got left=%0d err=%b ready=%b expected 0/0/1", sb.size(), o_err, o_wr_ready);
      end
   endtask

   task automatic test_illegal_write();
      int fw, wc, da, dc;
      logic war;
      apply_reset();
      drive_cycle(1'b1, 5'd17, 8'h55, 1'b0, 1'b0);
      idle_cycles(1);
      checks++;
      if (o_err !== 1'b1 || o_wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL illegal_err got err=%b ready=%b expected 1/1", o_err, o_wr_ready);
      end
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      idle_cycles(2);
      push_model();
      run_load(0, 0, fw, wc, da, dc, war);
      checks++;
      if (wc !== NUM_COEF || dc !== 1 || sb.size() !== 0) begin
         errors++;
         $display("FAIL illegal_load got we=%0d done=%0d left=%0d expected %0d/1/0", wc, dc, sb.size(), NUM_COEF);
      end
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_err_sticky got %b expected 1", o_err);
      end
   endtask

   task automatic test_commit_with_write();
      int fw, wc, da, dc;
      logic war;
      drive_cycle(1'b1, 5'd5, 8'h80, 1'b1, 1'b0);
      model[5] = 8'h80;
      idle_cycles(2);
      push_model();
      run_load(0, 0, fw, wc, da, dc, war);
      checks++;
      if (wc !== NUM_COEF || da !== NUM_COEF + 1 || sb.size() !== 0) begin
         errors++;
         $display("FAIL commit_write got we=%0d done_at=%0d left=%0d expected %0d/%0d/0",
                  wc, da, sb.size(), NUM_COEF, NUM_COEF + 1);
      end
   endtask

   task automatic test_commit_strobe_same();
      int fw, wc, da, dc, early;
      logic war;
      early = 0;
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
         if (o_coef_we !== 1'b0 || o_busy !== 1'b1) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL same_cycle_strobe got %0d cycles not armed-and-quiet expected 0", early);
      end
      push_model();
      run_load(0, 0, fw, wc, da, dc, war);
      checks++;
      if (fw !== 1 || wc !== NUM_COEF || dc !== 1) begin
         errors++;
         $display("FAIL same_cycle_load got first=%0d we=%0d done=%0d expected 1/%0d/1", fw, wc, dc, NUM_COEF);
      end
   endtask

   task automatic test_load_abuse();
      int fw, wc, da, dc;
      logic war;
      apply_reset();
      for (int k = 0; k < NUM_COEF; k++) begin
         drive_cycle(1'b1, NB_ADDR'(k), NBT_COEF'(8'hF0 - k), 1'b0, 1'b0);
         model[k] = NBT_COEF'(8'hF0 - k);
      end
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      idle_cycles(2);
      checks++;
      if (o_err !== 1'b0) begin
         errors++;
         $display("FAIL abuse_err_pre got %b expected 0", o_err);
      end
      push_model();
      run_load(4, 0, fw, wc, da, dc, war);
      checks++;
      if (fw !== 1 || wc !== NUM_COEF || da !== NUM_COEF + 1 || dc !== 1) begin
         errors++;
         $display("FAIL abuse_load got first=%0d we=%0d done_at=%0d done=%0d expected 1/%0d/%0d/1",
                  fw, wc, da, dc, NUM_COEF, NUM_COEF + 1);
      end
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL abuse_err got %b expected 1", o_err);
      end
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      idle_cycles(2);
      push_model();
      run_load(0, 0, fw, wc, da, dc, war);
      checks++;
      if (sb.size() !== 0 || wc !== NUM_COEF) begin
         errors++;
         $display("FAIL abuse_reload got left=%0d we=%0d expected 0/%0d", sb.size(), wc, NUM_COEF);
      end
   endtask

   task automatic test_reset_during_load();
      int fw, wc, da, dc;
      logic war;
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      idle_cycles(2);
      push_model();
      run_load(0, 8, fw, wc, da, dc, war);
      checks++;
      if (war !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_we got %b expected 0", war);
      end
      checks++;
      if (wc !== 8 || dc !== 0) begin
         errors++;
         $display("FAIL reset_abort got we=%0d done=%0d expected 8/0", wc, dc);
      end
      sb.delete();
      for (int i = 0; i < NUM_COEF; i++) model[i] = '0;
      @(negedge clk);
      i_reset    = 1'b1;
      i_wr_valid = 1'b1;
      i_wr_addr  = '0;
      i_wr_data  = 8'h7F;
      model[0]   = 8'h7F;
      idle_cycles(1);
      checks++;
      if (o_wr_ready !== 1'b1 || o_busy !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got ready=%b busy=%b err=%b expected 1/0/0", o_wr_ready, o_busy, o_err);
      end
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      idle_cycles(2);
      push_model();
      run_load(0, 0, fw, wc, da, dc, war);
      checks++;
      if (sb.size() !== 0 || wc !== NUM_COEF || dc !== 1) begin
         errors++;
         $display("FAIL reset_first_write got left=%0d we=%0d done=%0d expected 0/%0d/1",
                  sb.size(), wc, dc, NUM_COEF);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_illegal_write();
      test_commit_with_write();
      test_commit_strobe_same();
      test_load_abuse();
      test_reset_during_load();
      idle_cycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
